control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 88 ++++++++
 tb/tb_control_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded step sequencer producing the control word for a simple 8-bit CPU
module control_sequencer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    step_t       state;
    logic [2:0]  last_step;
    logic [15:0] word;

    // Index of the final microstep of the current opcode; fetch-only opcodes end at T1
    always_comb begin
        case (opcode)
            4'h1, 4'h4:                             last_step = 3'd3;
            4'h2, 4'h3:                             last_step = 3'd4;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF:     last_step = 3'd2;
            default:                                last_step = 3'd1;
        endcase
    end

    // Microcode table: fetch words are fixed, execute words depend on opcode and, at T2, on flags
    always_comb begin
        word = 16'h0000;
        case (state)
            T0: word = 16'h4004;
            T1: word = 16'h1408;
            T2: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4: word = 16'h4800;
                    4'h5:                   word = 16'h0A00;
                    4'h6:                   word = 16'h0802;
                    4'h7:                   word = flag_c ? 16'h0802 : 16'h0000;
                    4'h8:                   word = flag_z ? 16'h0802 : 16'h0000;
                    4'hE:                   word = 16'h0110;
                    4'hF:                   word = 16'h8000;
                    default:                word = 16'h0000;
                endcase
            end
            T3: begin
                case (opcode)
                    4'h1:       word = 16'h1200;
                    4'h2, 4'h3: word = 16'h1020;
                    4'h4:       word = 16'h2100;
                    default:    word = 16'h0000;
                endcase
            end
            T4: begin
                case (opcode)
                    4'h2:    word = 16'h0281;
                    4'h3:    word = 16'h02C1;
                    default: word = 16'h0000;
                endcase
            end
            default: word = 16'h0000;
        endcase
    end

    // Halt dominates; a disabled sequencer drives no control lines at all
    assign ctrl = halted ? 16'h8000 : (en ? word : 16'h0000);
    assign step = state;

    // Step advances or wraps at the instruction's last step; HLT at T2 latches the sticky halt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= T0;
            halted <= 1'b0;
        end else if (en && !halted) begin
            if (state == T2 && opcode == 4'hF) begin
                halted <= 1'b1;
                state  <= T0;
            end else if (state >= last_step) begin
                state <= T0;
            end else begin
                state <= step_t'(state + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench with a table-driven instruction model and random stimulus
module tb_control_sequencer;

    logic        clk = 1'b1;
    logic        rstn, en, flag_c, flag_z;
    logic [3:0]  opcode;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl   (ctrl),
        .step   (step),
        .halted (halted)
    );

    logic [19:0] exp_q[$];
    string       name_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          m_pos = 0;
    bit          m_h = 1'b0;
    event        sample_ev;

    // Instruction length in cycles
    function automatic int plen(input logic [3:0] op);
        case (op)
            4'h1, 4'h4:                         return 4;
            4'h2, 4'h3:                         return 5;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
            default:                            return 2;
        endcase
    endfunction

    // Control word of microstep idx; steps past the instruction's end carry no signals
    function automatic logic [15:0] uword(input logic [3:0] op, input int idx, input logic c, input logic z);
        logic [15:0] w[5];
        w = '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000};
        case (op)
            4'h1: begin w[2] = 16'h4800; w[3] = 16'h1200; end
            4'h2: begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h0281; end
            4'h3: begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h02C1; end
            4'h4: begin w[2] = 16'h4800; w[3] = 16'h2100; end
            4'h5: w[2] = 16'h0A00;
            4'h6: w[2] = 16'h0802;
            4'h7: w[2] = c ? 16'h0802 : 16'h0000;
            4'h8: w[2] = z ? 16'h0802 : 16'h0000;
            4'hE: w[2] = 16'h0110;
            4'hF: w[2] = 16'h8000;
            default: ;
        endcase
        return (idx < plen(op)) ? w[idx] : 16'h0000;
    endfunction

    task automatic apply(input logic r, input logic e, input logic [3:0] op, input logic c, input logic z, input string nm);
        logic [15:0] ec;
        rstn = r; en = e; opcode = op; flag_c = c; flag_z = z;
        if (!r) begin m_pos = 0; m_h = 1'b0; end
        ec = m_h ? 16'h8000 : (!e ? 16'h0000 : uword(op, m_pos, c, z));
        exp_q.push_back({ec, 3'(m_pos), m_h});
        name_q.push_back(nm);
    endtask

    task automatic cyc(input logic r, input logic e, input logic [3:0] op, input logic c, input logic z, input string nm);
        @(posedge clk);
        if (!rstn) begin
            m_pos = 0; m_h = 1'b0;
        end else if (!m_h && en) begin
            if (opcode == 4'hF && m_pos == 2) begin
                m_h = 1'b1; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1 >= plen(opcode)) ? 0 : m_pos + 1;
            end
        end
        #1 apply(r, e, op, c, z, nm);
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation
    logic [19:0] m_exp;
    string       m_name;
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                m_exp  = exp_q.pop_front();
                m_name = name_q.pop_front();
                compared++;
                if ({ctrl, step, halted} !== m_exp) begin
                    mismatched++;
                    $display("FAIL %s: got ctrl=%h step=%0d halted=%b, want ctrl=%h step=%0d halted=%b",
                             m_name, ctrl, step, halted, m_exp[19:4], m_exp[3:1], m_exp[0]);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic       r, e, c, z;
        logic [3:0] op;
        apply(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, "reset_en1");
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "reset_en0");
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, "add_seq");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, "add_to_t3");
        @(negedge clk);
        #1 apply(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, "reset_abort");
        #1 ->sample_ev;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, "jc_not_taken");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'h7, 1'b1, 1'b0, "jc_taken");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'h8, 1'b0, 1'b1, "jz_taken");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'h8, 1'b1, 1'b0, "jz_not_taken");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, "lda_fetch");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, "lda_freeze");
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, "lda_resume");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'hB, 1'b0, 1'b0, "undef_op");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, "halt_enter");
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'(i % 2), 4'h2, 1'($urandom_range(0, 1)), 1'b0, "halt_hold");
        cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, "halt_reset");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, "halt_release");
        op = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) >= 3);
            e = ($urandom_range(0, 9) != 0);
            c = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            if (m_pos <= 1 || $urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            cyc(r, e, op, c, z, "random");
        end
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
